reg_bank_init: RTL and testbench



---
 rtl/reg_bank_init_if.sv | 27 ++
 rtl/reg_bank_init.sv | 107 ++++++++++
 tb/tb_reg_bank_init.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/reg_bank_init_if.sv
// Register-file access bundle: one write port, two read ports and the ready flag.
// Latency: reads are combinational and writes land on the next rising edge.
// Backpressure: none; the master must hold off writes until ready is high.
interface reg_bank_init_if #(
    parameter int unsigned DATA_W = 32
);
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              ready;

    // Requester side: control unit, operand fetch and write-register select mux.
    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, ready
    );

    // Register file side.
    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        output ReadData1, ReadData2, ready
    );
endinterface

// File: rtl/reg_bank_init.sv
// 32-entry register file with a post-reset clearing sweep and write-through read bypass.
// Latency: 0-cycle reads, 1-edge writes; ready rises 32 edges after reset is released.
// Backpressure: writes are silently dropped while ready is low; reads return 0 then.
module reg_bank_init #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       SP_IDX  = 29,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(227)
) (
    input  logic                clk,
    input  logic                reset,
    reg_bank_init_if.slave      bus
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] regs_q [32];

    logic              wr_en;
    logic [4:0]        wr_idx;
    logic [DATA_W-1:0] wr_dat;

    // Zero-index guard, then same-cycle bypass of the write port, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rdy,
        input logic [4:0]        raddr,
        input logic              we,
        input logic [4:0]        waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (rdy && (raddr != 5'd0)) begin
            if (we && (waddr == raddr)) begin
                r = wdata;
            end else begin
                r = stored;
            end
        end
        return r;
    endfunction

    // Sweep control: walk idx through every entry, then hand over to user writes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        wr_en   = 1'b0;
        wr_idx  = bus.WriteReg;
        wr_dat  = bus.WriteData;
        case (state_q)
            INIT: begin
                wr_en  = 1'b1;
                wr_idx = idx_q;
                wr_dat = (idx_q == 5'(SP_IDX)) ? SP_INIT : '0;
                idx_d  = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                // Entry 0 is hardwired to zero, so writes to it never land.
                wr_en = bus.RegWrite && (bus.WriteReg != 5'd0);
            end
            default: begin
                state_d = INIT;
                idx_d   = 5'd0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control state register; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= 5'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    // Storage update; contents survive reset and are cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            regs_q[wr_idx] <= wr_dat;
        end
    end

    // Combinational read ports; RegWrite is only honoured for bypass once ready.
    always_comb begin
        bus.ReadData1 = read_port(ready_q, bus.ReadReg1, bus.RegWrite, bus.WriteReg,
                                  bus.WriteData, regs_q[bus.ReadReg1]);
        bus.ReadData2 = read_port(ready_q, bus.ReadReg2, bus.RegWrite, bus.WriteReg,
                                  bus.WriteData, regs_q[bus.ReadReg2]);
    end

    assign bus.ready = ready_q;

endmodule

// File: tb/tb_reg_bank_init.sv
module tb_reg_bank_init;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    // Reference state
    logic [31:0] mdl_mem [32];
    bit          mdl_ready;
    int          mdl_cnt;

    reg_bank_init_if #(.DATA_W(32)) bus ();

    reg_bank_init #(.DATA_W(32), .SP_IDX(29), .SP_INIT(32'd227)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected read result for one port, from the architectural rules.
    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        if (!mdl_ready || a == 5'd0) return 32'd0;
        if (bus.RegWrite && bus.WriteReg == a) return bus.WriteData;
        return mdl_mem[a];
    endfunction

    task automatic check_reads(input string tag);
        check({tag, ".rd1"}, bus.ReadData1, mdl_read(bus.ReadReg1));
        check({tag, ".rd2"}, bus.ReadData2, mdl_read(bus.ReadReg2));
    endtask

    // Apply one rising edge to the model, then to the DUT; returns #1 after the edge.
    task automatic tick();
        if (reset) begin
            mdl_cnt   = 0;
            mdl_ready = 1'b0;
        end else if (!mdl_ready) begin
            mdl_cnt++;
            if (mdl_cnt == 32) begin
                foreach (mdl_mem[i]) mdl_mem[i] = 32'd0;
                mdl_mem[29] = 32'd227;
                mdl_ready   = 1'b1;
            end
        end else if (bus.RegWrite && bus.WriteReg != 5'd0) begin
            mdl_mem[bus.WriteReg] = bus.WriteData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.RegWrite  = we;
        bus.WriteReg  = a;
        bus.WriteData = d;
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.ReadReg1 = a1;
        bus.ReadReg2 = a2;
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        mdl_ready = 1'b0;
        mdl_cnt   = 0;
        foreach (mdl_mem[i]) mdl_mem[i] = 32'hx;
        reset = 1'b1;
        set_wr(1'b0, 5'd0, 32'd0);
        set_rd(5'd29, 5'd10);
        @(negedge clk);

        // Reset state
        tick();
        check("reset.ready", {31'd0, bus.ready}, 32'd0);
        check_reads("reset");

        // Sweep with a write held on the bus throughout
        reset = 1'b0;
        set_wr(1'b1, 5'd10, 32'hFFFF_FFFF);
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("sweep.ready@%0d", e), {31'd0, bus.ready}, (e == 32) ? 32'd1 : 32'd0);
            if (e < 32) begin
                check($sformatf("sweep.rd1@%0d", e), bus.ReadData1, 32'd0);
                check($sformatf("sweep.rd2@%0d", e), bus.ReadData2, 32'd0);
            end
        end
        set_wr(1'b0, 5'd10, 32'hFFFF_FFFF);
        set_rd(5'd29, 5'd5);
        check("run.sp", bus.ReadData1, 32'd227);
        check("run.r5", bus.ReadData2, 32'd0);
        set_rd(5'd10, 5'd10);
        check("init_wr_dropped", bus.ReadData1, 32'd0);

        // Plain write then read
        set_wr(1'b1, 5'd8, 32'hDEAD_BEEF);
        tick();
        set_wr(1'b0, 5'd8, 32'hDEAD_BEEF);
        set_rd(5'd8, 5'd9);
        check("wr8.rd1", bus.ReadData1, 32'hDEAD_BEEF);
        check("wr9.rd2", bus.ReadData2, 32'd0);

        // Zero register
        set_wr(1'b1, 5'd0, 32'h1234_5678);
        set_rd(5'd0, 5'd0);
        check("zero.same_cycle", bus.ReadData1, 32'd0);
        tick();
        set_wr(1'b0, 5'd0, 32'h1234_5678);
        set_rd(5'd0, 5'd0);
        check("zero.after", bus.ReadData1, 32'd0);

        // Bypass on both ports
        set_wr(1'b1, 5'd31, 32'h0040_0004);
        set_rd(5'd31, 5'd31);
        check("byp.rd1", bus.ReadData1, 32'h0040_0004);
        check("byp.rd2", bus.ReadData2, 32'h0040_0004);
        tick();
        set_wr(1'b0, 5'd31, 32'h0040_0004);
        set_rd(5'd31, 5'd31);
        check("byp.after1", bus.ReadData1, 32'h0040_0004);
        check("byp.after2", bus.ReadData2, 32'h0040_0004);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            set_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 3) == 0) set_rd(bus.WriteReg, 5'($urandom_range(0, 31)));
            else if ($urandom_range(0, 3) == 0) set_rd(5'($urandom_range(0, 31)), bus.WriteReg);
            else set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            check_reads($sformatf("rand%0d", n));
            tick();
        end

        // Reset in RUN and again mid-sweep
        set_wr(1'b1, 5'd29, 32'h100);
        tick();
        set_wr(1'b0, 5'd29, 32'h100);
        set_rd(5'd29, 5'd8);
        check("sp_overwrite", bus.ReadData1, 32'h100);
        reset = 1'b1;
        tick();
        check("rst_run.ready", {31'd0, bus.ready}, 32'd0);
        check_reads("rst_run");
        reset = 1'b0;
        for (int e = 1; e <= 15; e++) tick();
        check("midsweep.ready", {31'd0, bus.ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("resweep.ready@%0d", e), {31'd0, bus.ready}, (e == 32) ? 32'd1 : 32'd0);
        end
        set_rd(5'd29, 5'd8);
        check("resweep.sp", bus.ReadData1, 32'd227);
        check("resweep.r8", bus.ReadData2, 32'd0);
        check_reads("resweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
